// File: rtl/mips_cpu_bus_pkg.sv
// mips_cpu_bus_pkg: shared arbiter state encoding and timeout default.
package mips_cpu_bus_pkg;
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, ABORT} bus_state_e;
  localparam int TIMEOUT_DEFAULT = 16;
endpackage

// File: rtl/mips_cpu_bus_arbiter.sv
// mips_cpu_bus_arbiter: two-master (fetch/data) arbiter onto one wait-stated bus.
// Data has priority; a one-shot fairness bit lets a pending fetch go after a data transfer.
module mips_cpu_bus_arbiter
  import mips_cpu_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_address,
  input  logic        i_read,
  input  logic        i_write,
  input  logic [31:0] i_writedata,
  input  logic [3:0]  i_byteenable,
  output logic [31:0] i_readdata,
  output logic        i_waitrequest,
  input  logic [31:0] d_address,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic [31:0] d_readdata,
  output logic        d_waitrequest,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        bus_error
);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  bus_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d, fair_q, fair_d, own_d_q, own_d_d;
  logic i_req, d_req, g_read, g_write, g_req, g_both;
  assign i_req = i_read | i_write;
  assign d_req = d_read | d_write;
  assign g_read = (state_q == GRANT_D) ? d_read : i_read;
  assign g_write = (state_q == GRANT_D) ? d_write : i_write;
  assign g_req = g_read | g_write;
  assign g_both = g_read & g_write;
  assign bus_error = err_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      fair_q  <= 1'b0;
      own_d_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fair_q  <= fair_d;
      own_d_q <= own_d_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fair_d  = fair_q;
    own_d_d = own_d_q;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        fair_d = 1'b0;
        if (i_req && (fair_q || !d_req)) begin
          state_d = GRANT_I;
          own_d_d = 1'b0;
        end else if (d_req) begin
          state_d = GRANT_D;
          own_d_d = 1'b1;
        end
      end
      GRANT_I, GRANT_D: begin
        if (!g_req) state_d = IDLE;
        else if (g_both) begin
          state_d = ABORT;
          err_d   = 1'b1;
        end else if (!waitrequest) begin
          state_d = IDLE;
          fair_d  = (state_q == GRANT_D);
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = ABORT;
          err_d   = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // An illegal read+write cycle keeps the owner stalled; ABORT releases it next cycle.
  always_comb begin
    address       = '0;
    read          = 1'b0;
    write         = 1'b0;
    writedata     = '0;
    byteenable    = '0;
    i_waitrequest = 1'b1;
    d_waitrequest = 1'b1;
    i_readdata    = readdata;
    d_readdata    = readdata;
    if (state_q == GRANT_D) begin
      address       = d_address;
      read          = d_read & ~d_write;
      write         = d_write & ~d_read;
      writedata     = d_writedata;
      byteenable    = d_byteenable;
      d_waitrequest = g_both | waitrequest;
    end else if (state_q == GRANT_I) begin
      address       = i_address;
      read          = i_read & ~i_write;
      write         = i_write & ~i_read;
      writedata     = i_writedata;
      byteenable    = i_byteenable;
      i_waitrequest = g_both | waitrequest;
    end else if (state_q == ABORT) begin
      d_waitrequest = ~own_d_q;
      i_waitrequest = own_d_q;
      d_readdata    = own_d_q ? '0 : readdata;
      i_readdata    = own_d_q ? readdata : '0;
    end
  end
endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// tb_mips_cpu_bus_arbiter: directed vectors for the fetch/data bus arbiter.
module tb_mips_cpu_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_address, i_writedata, i_readdata;
  logic        i_read, i_write, i_waitrequest;
  logic [3:0]  i_byteenable;
  logic [31:0] d_address, d_writedata, d_readdata;
  logic        d_read, d_write, d_waitrequest;
  logic [3:0]  d_byteenable;
  logic [31:0] address, writedata, readdata;
  logic        read, write, waitrequest, bus_error;
  logic [3:0]  byteenable;
  int n_chk = 0;
  int n_err = 0;

  mips_cpu_bus_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .i_address(i_address), .i_read(i_read), .i_write(i_write),
    .i_writedata(i_writedata), .i_byteenable(i_byteenable),
    .i_readdata(i_readdata), .i_waitrequest(i_waitrequest),
    .d_address(d_address), .d_read(d_read), .d_write(d_write),
    .d_writedata(d_writedata), .d_byteenable(d_byteenable),
    .d_readdata(d_readdata), .d_waitrequest(d_waitrequest),
    .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdata(readdata), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    {i_address, i_read, i_write, i_writedata, i_byteenable} = '0;
    {d_address, d_read, d_write, d_writedata, d_byteenable} = '0;
    waitrequest = 1'b0;
    readdata = 32'h1234_5678;
    #1;
    check("rst_read", read, 0);
    check("rst_write", write, 0);
    check("rst_iwait", i_waitrequest, 1);
    check("rst_dwait", d_waitrequest, 1);
    check("rst_err", bus_error, 0);
    i_read = 1'b1; d_read = 1'b1;
    step; step;
    check("rst_hold_read", read, 0);
    check("rst_hold_iwait", i_waitrequest, 1);
    check("rst_hold_dwait", d_waitrequest, 1);
    i_read = 1'b0; d_read = 1'b0;
    reset = 1'b1;
    step;
    // single fetch, zero-wait slave
    i_read = 1'b1; i_address = 32'hBFC0_0000;
    #1;
    check("f_idle_read", read, 0);
    check("f_idle_iwait", i_waitrequest, 1);
    step;
    check("f_addr", address, 32'hBFC0_0000);
    check("f_read", read, 1);
    check("f_iwait", i_waitrequest, 0);
    check("f_dwait", d_waitrequest, 1);
    check("f_rdata", i_readdata, 32'h1234_5678);
    i_read = 1'b0;
    step;
    check("f_done_read", read, 0);
    check("f_done_addr", address, 0);
    // simultaneous requests: data first, then fetch via fairness despite new data request
    i_read = 1'b1; i_address = 32'hBFC0_0004;
    d_read = 1'b1; d_address = 32'h0000_0001;
    step;
    check("p_d_addr", address, 32'h0000_0001);
    check("p_d_dwait", d_waitrequest, 0);
    check("p_d_iwait", i_waitrequest, 1);
    d_address = 32'h0000_0008;
    step;
    check("p_bubble_read", read, 0);
    check("p_bubble_iwait", i_waitrequest, 1);
    step;
    check("p_i_addr", address, 32'hBFC0_0004);
    check("p_i_iwait", i_waitrequest, 0);
    check("p_i_dwait", d_waitrequest, 1);
    i_read = 1'b0;
    step;
    check("p_bubble2_read", read, 0);
    step;
    check("p_d2_addr", address, 32'h0000_0008);
    check("p_d2_dwait", d_waitrequest, 0);
    d_read = 1'b0;
    step;
    // data write with three wait states
    d_write = 1'b1; d_address = 32'h0000_0100; d_writedata = 32'h0000_00C0; d_byteenable = 4'hF;
    waitrequest = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step;
      waitrequest = (k < 3);
      #1;
      check($sformatf("w_write%0d", k), write, 1);
      check($sformatf("w_wdata%0d", k), writedata, 32'h0000_00C0);
      check($sformatf("w_be%0d", k), byteenable, 4'hF);
      check($sformatf("w_dwait%0d", k), d_waitrequest, (k < 3) ? 1 : 0);
    end
    d_write = 1'b0;
    step;
    check("w_idle_write", write, 0);
    // illegal read+write from data requester
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h0000_0200;
    waitrequest = 1'b1; readdata = 32'hDEAD_BEEF;
    step;
    check("rw_read", read, 0);
    check("rw_write", write, 0);
    check("rw_dwait", d_waitrequest, 1);
    check("rw_err_pre", bus_error, 0);
    step;
    check("rw_err", bus_error, 1);
    check("rw_abort_dwait", d_waitrequest, 0);
    check("rw_abort_rdata", d_readdata, 0);
    check("rw_abort_iwait", i_waitrequest, 1);
    check("rw_abort_irdata", i_readdata, 32'hDEAD_BEEF);
    d_read = 1'b0; d_write = 1'b0;
    step;
    check("rw_sticky", bus_error, 1);
    check("rw_idle_dwait", d_waitrequest, 1);
    // reset asserted in second wait cycle of a fetch
    i_read = 1'b1; i_address = 32'h0000_0080;
    step; step;
    check("r_wait2_read", read, 1);
    #2;
    reset = 1'b0;
    #1;
    check("r_async_read", read, 0);
    check("r_async_iwait", i_waitrequest, 1);
    check("r_async_err", bus_error, 0);
    step;
    check("r_held_read", read, 0);
    waitrequest = 1'b0;
    reset = 1'b1;
    step;
    check("r_after_addr", address, 32'h0000_0080);
    check("r_after_read", read, 1);
    check("r_after_iwait", i_waitrequest, 0);
    i_read = 1'b0;
    step;
    // timeout: waitrequest stuck high on a fetch
    i_read = 1'b1; i_address = 32'h0000_0040; waitrequest = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step;
      check($sformatf("t_read%0d", k), read, 1);
      check($sformatf("t_iwait%0d", k), i_waitrequest, 1);
    end
    check("t_err_pre", bus_error, 0);
    step;
    check("t_abort_read", read, 0);
    check("t_abort_iwait", i_waitrequest, 0);
    check("t_abort_rdata", i_readdata, 0);
    check("t_abort_dwait", d_waitrequest, 1);
    check("t_err", bus_error, 1);
    i_read = 1'b0;
    step;
    check("t_idle_iwait", i_waitrequest, 1);
    check("t_sticky", bus_error, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mips_cpu_bus_arbiter.md
MIPS_CPU_BUS_ARBITER -- requirements
Module: mips_cpu_bus_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, the maximum number of consecutive granted cycles with waitrequest high before abort.
REQ-002 The block SHALL have the port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port reset, input, 1, asynchronous active-low reset: 0 resets immediately, release is synchronous to clk.
REQ-004 The block SHALL have the ports i_address 32, i_read 1, i_write 1, i_writedata 32 and i_byteenable 4, all inputs, forming the instruction-fetch requester.
REQ-005 The block SHALL have the outputs i_readdata 32 and i_waitrequest 1 for the instruction-fetch requester.
REQ-006 The block SHALL have the ports d_address, d_read, d_write, d_writedata, d_byteenable, d_readdata and d_waitrequest, the data requester, with the same widths and directions as the i_ set.
REQ-007 The block SHALL have the outputs address 32, read 1, write 1, writedata 32 and byteenable 4, forming the shared memory bus.
REQ-008 The block SHALL have the inputs waitrequest 1 and readdata 32, the bus slave response.
REQ-009 The block SHALL have the output bus_error 1, a sticky error flag.

Function
REQ-010 The FSM SHALL have the states IDLE, GRANT_I, GRANT_D and ABORT, with a registered state.
REQ-011 In IDLE, if d_read|d_write is set, the next state SHALL be GRANT_D; else if i_read|i_write is set, GRANT_I; else IDLE. Data has fixed priority over fetch.
REQ-012 In GRANT_x, the bus outputs SHALL be combinationally muxed from the granted requester; in IDLE and ABORT, read=write=0, byteenable=0, and address and writedata are 0.
REQ-013 The granted requester's waitrequest SHALL equal the bus waitrequest; the non-granted requester's waitrequest SHALL be 1, except as stated in REQ-018.
REQ-014 readdata SHALL drive both i_readdata and d_readdata unchanged; it is valid only for the requester seeing waitrequest low on a read.
REQ-015 A transfer SHALL complete in a GRANT_x cycle with the request active and waitrequest=0; the next state is IDLE, and the re-arbitration bubble is 1 cycle.
REQ-016 Minimum latency SHALL be: request seen in cycle N, grant in N+1, completion in N+1 if the slave has zero wait.
REQ-017 If the granted requester drops read and write while granted, the next state SHALL be IDLE, with no error.
REQ-018 If the granted requester asserts read and write together, the bus SHALL drive read=write=0, bus_error SHALL be set, and the next state SHALL be ABORT.
REQ-019 A cycle counter SHALL increment each GRANT_x cycle with waitrequest=1 and clear on grant entry.
REQ-020 When the counter reaches TIMEOUT_CYCLES-1 with waitrequest still 1, the next state SHALL be ABORT and bus_error SHALL be set.
REQ-021 The ABORT state SHALL last 1 cycle, during which the aborted requester sees waitrequest=0 and readdata=0, and the other requester sees 1; the next state is IDLE.
REQ-022 bus_error SHALL be sticky until reset.
REQ-023 A new request arriving during another requester's grant SHALL wait, with waitrequest=1, and SHALL NOT preempt the grant.
REQ-024 After a completed GRANT_D, a pending fetch SHALL be granted before any new data request is seen in IDLE (one-shot fairness bit), preventing starvation.

Reset
REQ-025 While reset=0, the state SHALL be IDLE, the counter 0, bus_error 0 and the fairness bit 0; bus read/write SHALL be 0 and both requester waitrequests SHALL be 1.
REQ-026 Reset asserted mid-transfer SHALL abandon the transfer immediately, with no completion signalled.

Structure
REQ-027 The state enum and the TIMEOUT default SHALL live in the shared package mips_cpu_bus_pkg.
REQ-028 The block SHALL be a single module with no sub-module; the mux is inline and the counter width is $clog2(TIMEOUT_CYCLES)+1.

Verification
REQ-029 i_read=1, i_address=BFC00000, waitrequest=0 -> address=BFC00000 and read=1 in the next cycle, and i_waitrequest=0 in that cycle.
REQ-030 i_read and d_read (address 1) in the same cycle -> address=1 is served first; fetch is granted 2 cycles later.
REQ-031 d_write=1, d_writedata=000000C0, byteenable=1111, waitrequest high for 3 cycles -> write=1 held for 4 cycles, then IDLE.
REQ-032 waitrequest stuck at 1 with TIMEOUT_CYCLES=16 -> ABORT after 16 granted cycles, the requester gets readdata=0, bus_error=1.
REQ-033 d_read and d_write together -> bus read=write=0 and bus_error=1; ABORT releases the requester.
REQ-034 reset=0 in the second wait cycle of a read -> read=0 and state IDLE immediately, without waiting for a clock edge; operation normal after release.
